// File: rtl/register_file_pkg.sv
// Shared constants for the register file: index width, special register
// indices and the architectural reset values of sp/gp.
package register_file_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREGS_MAX = 1 << REG_IDX_W;

  localparam logic [REG_IDX_W-1:0] X0 = 5'd0;
  localparam logic [REG_IDX_W-1:0] SP = 5'd2;
  localparam logic [REG_IDX_W-1:0] GP = 5'd3;

  localparam logic [31:0] SP_INIT_DEF = 32'h7FFF_EFFC;
  localparam logic [31:0] GP_INIT_DEF = 32'h1000_8000;

  localparam logic [15:0] WCNT_MAX = 16'hFFFF;

endpackage

// File: rtl/register_file_sync_register.sv
// One architectural register: N-bit flop with load enable and a
// synchronous active-low reset to a per-instance value.
//   clk, i_rst_n, i_en, i_d -> o_q
module sync_register #(
  parameter int unsigned     N       = 32,
  parameter logic [N-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/register_file.sv
// RISC-V integer register file: 2 combinational read ports, 1 write port,
// optional same-cycle write forwarding and a saturating write counter.
//   clk, reset (sync, active-low), reg_write, write_register, write_data
//   read_register_1/2 -> read_data_1/2, write_count
module register_file
  import register_file_pkg::*;
#(
  parameter int unsigned  N        = 32,
  parameter int unsigned  NUM_REGS = 32,
  parameter logic [N-1:0] SP_INIT  = N'(SP_INIT_DEF),
  parameter logic [N-1:0] GP_INIT  = N'(GP_INIT_DEF),
  parameter bit           BYPASS   = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reg_write,
  input  logic [REG_IDX_W-1:0] write_register,
  input  logic [N-1:0]         write_data,
  input  logic [REG_IDX_W-1:0] read_register_1,
  input  logic [REG_IDX_W-1:0] read_register_2,
  output logic [N-1:0]         read_data_1,
  output logic [N-1:0]         read_data_2,
  output logic [15:0]          write_count
);

  logic                 w_commit;
  logic [NREGS_MAX-1:0] w_dec;
  logic [NREGS_MAX-1:0] w_we;
  logic [N-1:0]         w_regs [NREGS_MAX];
  logic                 w_fwd_1;
  logic                 w_fwd_2;
  logic [15:0]          r_write_count;

  // Writes to x0 or to unimplemented indices are dropped entirely.
  assign w_commit = reg_write
                 && (write_register != X0)
                 && (32'(write_register) < NUM_REGS);

  assign w_dec = NREGS_MAX'(1) << write_register;
  assign w_we  = w_commit ? w_dec : '0;

  // Storage is laid out over the full index space; x0 and indices past
  // NUM_REGS are hard zeros so the read mux never needs a range check.
  for (genvar i = 0; i < NREGS_MAX; i++) begin : g_reg
    if (i == 0 || i >= NUM_REGS) begin : g_zero
      assign w_regs[i] = '0;
    end else begin : g_ff
      localparam logic [N-1:0] RV =
        (i == int'(SP)) ? SP_INIT :
        (i == int'(GP)) ? GP_INIT : '0;
      sync_register #(
        .N       (N),
        .RST_VAL (RV)
      ) u_reg (
        .clk     (clk),
        .i_rst_n (reset),
        .i_en    (w_we[i]),
        .i_d     (write_data),
        .o_q     (w_regs[i])
      );
    end
  end

  // Forwarding is off while reset is held: the write will be lost.
  assign w_fwd_1 = BYPASS && reset && w_commit
                && (write_register == read_register_1);
  assign w_fwd_2 = BYPASS && reset && w_commit
                && (write_register == read_register_2);

  always_comb begin
    read_data_1 = w_regs[read_register_1];
    if (w_fwd_1) begin
      read_data_1 = write_data;
    end
  end

  always_comb begin
    read_data_2 = w_regs[read_register_2];
    if (w_fwd_2) begin
      read_data_2 = write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_write_count <= '0;
    end else if (w_commit && r_write_count != WCNT_MAX) begin
      r_write_count <= r_write_count + 16'd1;
    end
  end

  assign write_count = r_write_count;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: a bypassing 32-entry instance
// checked against a vector table, a non-bypassing 16-entry one against a model.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic [4:0]  read_register_1;
  logic [4:0]  read_register_2;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic [15:0] wc_a, wc_b;

  int n_pass = 0;
  int n_tot  = 0;

  register_file dut (
    .clk             (clk),
    .reset           (reset),
    .reg_write       (reg_write),
    .write_register  (write_register),
    .write_data      (write_data),
    .read_register_1 (read_register_1),
    .read_register_2 (read_register_2),
    .read_data_1     (rd1_a),
    .read_data_2     (rd2_a),
    .write_count     (wc_a)
  );

  register_file #(
    .NUM_REGS (16),
    .BYPASS   (1'b0)
  ) dut_nb (
    .clk             (clk),
    .reset           (reset),
    .reg_write       (reg_write),
    .write_register  (write_register),
    .write_data      (write_data),
    .read_register_1 (read_register_1),
    .read_register_2 (read_register_2),
    .read_data_1     (rd1_b),
    .read_data_2     (rd2_b),
    .write_count     (wc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          frc;
    logic        rst_n;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [15:0] ec;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] e1, e2, n1, n2;
    logic [15:0] ec, nc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_b [32];
  logic [15:0] cnt_b;

  // Reference for the 16-entry, non-forwarding instance.
  function automatic logic [31:0] mrd(logic [4:0] idx);
    if (idx == 0 || idx >= 16) return 32'h0;
    return m_b[idx];
  endfunction

  task automatic model_edge(input logic rst_n, input logic we,
                            input logic [4:0] wa, input logic [31:0] wd);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_b[i] = 32'h0;
      m_b[2] = 32'h7FFF_EFFC;
      m_b[3] = 32'h1000_8000;
      cnt_b  = 16'h0;
    end else if (we && wa != 0 && wa < 16) begin
      m_b[wa] = wd;
      if (cnt_b != 16'hFFFF) cnt_b = cnt_b + 16'd1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h want %08h", nm, act, exp);
  endtask

  task automatic step(input vec_t v);
    exp_t x;
    reset           = v.rst_n;
    reg_write       = v.we;
    write_register  = v.wa;
    write_data      = v.wd;
    read_register_1 = v.ra1;
    read_register_2 = v.ra2;
    x.name = v.name;
    x.e1 = v.e1;
    x.e2 = v.e2;
    x.ec = v.ec;
    x.n1 = mrd(v.ra1);
    x.n2 = mrd(v.ra2);
    x.nc = cnt_b;
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    chk({x.name, ".a.rd1"}, rd1_a, x.e1);
    chk({x.name, ".a.rd2"}, rd2_a, x.e2);
    chk({x.name, ".a.cnt"}, 32'(wc_a), 32'(x.ec));
    chk({x.name, ".b.rd1"}, rd1_b, x.n1);
    chk({x.name, ".b.rd2"}, rd2_b, x.n2);
    chk({x.name, ".b.cnt"}, 32'(wc_b), 32'(x.nc));
    @(posedge clk);
    model_edge(v.rst_n, v.we, v.wa, v.wd);
    @(negedge clk);
  endtask

  vec_t tbl[$];
  logic [31:0] exp_rst;

  initial begin
    tbl = '{
      '{"wr5",    0, 1, 1, 5,  32'hDEAD_BEEF, 2,  3,
        32'h7FFF_EFFC, 32'h1000_8000, 16'd0},
      '{"rd5",    0, 1, 0, 0,  32'h0,         5,  5,
        32'hDEAD_BEEF, 32'hDEAD_BEEF, 16'd1},
      '{"wr0",    0, 1, 1, 0,  32'hFFFF_FFFF, 0,  5,
        32'h0,         32'hDEAD_BEEF, 16'd1},
      '{"rd0",    0, 1, 0, 0,  32'h0,         0,  0,
        32'h0,         32'h0,         16'd1},
      '{"byp7",   0, 1, 1, 7,  32'h1234_5678, 7,  5,
        32'h1234_5678, 32'hDEAD_BEEF, 16'd1},
      '{"rd7",    0, 1, 0, 0,  32'h0,         7,  7,
        32'h1234_5678, 32'h1234_5678, 16'd2},
      '{"wr20",   0, 1, 1, 20, 32'hCAFE_F00D, 20, 31,
        32'hCAFE_F00D, 32'h0,         16'd2},
      '{"wr31",   0, 1, 1, 31, 32'h55AA_55AA, 20, 31,
        32'hCAFE_F00D, 32'h55AA_55AA, 16'd3},
      '{"rd31",   0, 1, 0, 0,  32'h0,         31, 1,
        32'h55AA_55AA, 32'h0,         16'd4},
      '{"rstcol", 0, 0, 1, 2,  32'hAAAA_AAAA, 2,  5,
        32'h7FFF_EFFC, 32'hDEAD_BEEF, 16'd4},
      '{"postrst",0, 1, 0, 0,  32'h0,         2,  5,
        32'h7FFF_EFFC, 32'h0,         16'd0},
      '{"sat1",   1, 1, 1, 1,  32'h1,         1,  0,
        32'h1,         32'h0,         16'hFFFE},
      '{"sat2",   0, 1, 1, 1,  32'h2,         1,  0,
        32'h2,         32'h0,         16'hFFFF},
      '{"sat3",   0, 1, 1, 1,  32'h3,         1,  0,
        32'h3,         32'h0,         16'hFFFF},
      '{"sathold",0, 1, 0, 0,  32'h0,         1,  0,
        32'h3,         32'h0,         16'hFFFF}
    };

    reset = 1'b0;
    reg_write = 1'b0;
    write_register = '0;
    write_data = '0;
    read_register_1 = '0;
    read_register_2 = '0;
    cnt_b = 16'h0;
    for (int i = 0; i < 32; i++) m_b[i] = 32'h0;

    @(negedge clk);
    @(posedge clk);
    model_edge(1'b0, 1'b0, 5'd0, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      read_register_1 = 5'(i);
      read_register_2 = 5'(i);
      #1;
      exp_rst = (i == 2) ? 32'h7FFF_EFFC :
                (i == 3) ? 32'h1000_8000 : 32'h0;
      chk($sformatf("rst.a.x%0d.p1", i), rd1_a, exp_rst);
      chk($sformatf("rst.a.x%0d.p2", i), rd2_a, exp_rst);
      chk($sformatf("rst.b.x%0d", i), rd1_b, mrd(5'(i)));
    end
    chk("rst.a.cnt", 32'(wc_a), 32'h0);
    chk("rst.b.cnt", 32'(wc_b), 32'h0);
    @(negedge clk);

    foreach (tbl[k]) begin
      if (tbl[k].frc) begin
        force dut.r_write_count = 16'hFFFE;
        force dut_nb.r_write_count = 16'hFFFE;
        @(posedge clk);
        @(negedge clk);
        release dut.r_write_count;
        release dut_nb.r_write_count;
        cnt_b = 16'hFFFE;
      end
      step(tbl[k]);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
